wb_select_stage: RTL

Parametrised writeback stage for the pipelined datapath. It selects one of `NUM_SRC` result sources (ALU, load data, link PC, …), applies byte/halfword load extraction with sign/zero extension, and registers the result toward the register-file write port. A two-entry skid buffer gives a valid/ready handshake on both sides, so a busy register-file port back-pressures MEM without losing beats. This block replaces the fixed two-input memory-to-register select.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_load_align.sv | 50 +++++
 rtl/wb_select_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared types and helpers for the writeback select stage.
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Upper bounds for the stored entry; the stage zero-fills unused high bits.
    localparam int c_MAX_DATA_W = 64;
    localparam int c_MAX_REG_AW = 8;

    typedef enum logic [1:0] {
        LD_WORD = 2'd0,
        LD_HALF = 2'd1,
        LD_BYTE = 2'd2,
        LD_RSVD = 2'd3
    } ld_size_t;

    typedef struct packed {
        logic                    valid;
        logic                    we;
        logic [c_MAX_REG_AW-1:0] rd;
        logic [c_MAX_DATA_W-1:0] data;
        logic                    sel_err;
    } wb_entry_t;

    // Writes to register 0 are suppressed.
    function automatic logic wb_zero_reg(input logic we, input logic [c_MAX_REG_AW-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module  : wb_load_align
// Brief   : Little-endian byte/halfword lane select with sign/zero extension.
// Revision: 1.0 - initial release
// ============================================================================
module wb_load_align
    import wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_ld_size,
    input  logic              i_ld_unsigned,
    input  logic [OFF_W-1:0]  i_byte_off,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [OFF_W-1:0] w_half_idx;

    // Halfword lanes are naturally aligned; offset bit 0 is dropped.
    assign w_half_idx = i_byte_off >> 1;

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (i_byte_off == OFF_W'(i)) w_byte = i_data[8*i +: 8];
        end
    end

    always_comb begin
        w_half = '0;
        for (int i = 0; i < DATA_W/16; i++) begin
            if (w_half_idx == OFF_W'(i)) w_half = i_data[16*i +: 16];
        end
    end

    always_comb begin
        case (ld_size_t'(i_ld_size))
            LD_HALF: o_data = i_ld_unsigned ? DATA_W'(w_half) : DATA_W'($signed(w_half));
            LD_BYTE: o_data = i_ld_unsigned ? DATA_W'(w_byte) : DATA_W'($signed(w_byte));
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_select_stage
// Brief   : Writeback source select + load extract, two-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module wb_select_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_SRC  = 4,
    parameter  int LOAD_SRC = 1,
    parameter  int REG_AW   = 5,
    localparam int SEL_W    = $clog2(NUM_SRC),
    localparam int OFF_W    = $clog2(DATA_W/8)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [1:0]                in_ld_size,
    input  logic                      in_ld_unsigned,
    input  logic [OFF_W-1:0]          in_byte_off,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic                      in_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_we,
    output logic [REG_AW-1:0]         out_rd,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sel_err
);

    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_data;
    logic              w_sel_err;
    logic              w_is_load;
    logic              w_accept;
    logic              w_drain;
    logic              w_unused_hi;
    wb_entry_t         w_new;
    wb_entry_t         r_main;
    wb_entry_t         r_skid;

    always_comb begin
        w_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) w_src = in_src[k*DATA_W +: DATA_W];
        end
    end

    assign w_sel_err = {1'b0, in_sel} >= (SEL_W+1)'(NUM_SRC);
    assign w_is_load = in_sel == SEL_W'(LOAD_SRC);

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_data        (w_src),
        .i_ld_size     (in_ld_size),
        .i_ld_unsigned (in_ld_unsigned),
        .i_byte_off    (in_byte_off),
        .o_data        (w_aligned)
    );

    assign w_data = w_sel_err ? '0 : (w_is_load ? w_aligned : w_src);

    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.we      = wb_zero_reg(in_we, c_MAX_REG_AW'(in_rd));
        w_new.rd      = c_MAX_REG_AW'(in_rd);
        w_new.data    = c_MAX_DATA_W'(w_data);
        w_new.sel_err = w_sel_err;
    end

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready = !r_skid.valid;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_main.valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (w_drain) begin
            if (r_skid.valid) begin
                r_main <= r_skid;
                r_skid <= '0;
            end else if (w_accept) begin
                r_main <= w_new;
            end else begin
                r_main <= '0;
            end
        end else if (w_accept) begin
            if (r_main.valid) r_skid <= w_new;
            else              r_main <= w_new;
        end
    end

    assign out_valid   = r_main.valid;
    assign out_we      = r_main.we;
    assign out_rd      = r_main.rd[REG_AW-1:0];
    assign out_data    = r_main.data[DATA_W-1:0];
    assign out_sel_err = r_main.sel_err;

    // High bits of the fixed-width entry are always zero.
    assign w_unused_hi = ^{r_main, r_skid};

endmodule
`default_nettype wire
